// File: rtl/fsm_pkg.sv
// Shared definitions for the frame synchroniser: controller state encodings
// and the sync-word width.
package fsm_pkg;

    localparam int PAT_W = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

endpackage

// File: rtl/sync_word_det.sv
// Serial sync-word detector: a PAT_W-bit shift window compared against
// PATTERN as each qualified bit arrives.
module sync_word_det
    import fsm_pkg::*;
#(
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic in,
    input  logic in_valid,
    output logic match
);

    logic [PAT_W-1:0] r_window;
    logic [PAT_W-1:0] w_window_next;

    // match looks at the window including the bit being sampled this edge
    assign w_window_next = {r_window[PAT_W-2:0], in};
    assign match         = in_valid && (w_window_next == PATTERN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_window <= '0;
        end else if (clr) begin
            r_window <= '0;
        end else if (in_valid) begin
            r_window <= w_window_next;
        end
    end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame synchronisation controller: hunts for a sync word, verifies it recurs
// every FRAME_LEN valid bits, then holds lock until LOSS_CNT consecutive misses.
module frame_sync_ctrl
    import fsm_pkg::*;
#(
    parameter logic [PAT_W-1:0] PATTERN   = 4'b1010,
    parameter int               FRAME_LEN = 16,
    parameter int               LOCK_CNT  = 2,
    parameter int               LOSS_CNT  = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic       in,
    input  logic       in_valid,
    output logic       lock,
    output logic       sync_pulse,
    output logic [1:0] state,
    output logic [2:0] miss_cnt
);

    localparam int               POS_W     = $clog2(FRAME_LEN);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(FRAME_LEN - 1);
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
    localparam logic [2:0]       HIT_LOCK  = 3'(LOCK_CNT);
    localparam logic [2:0]       MISS_LOSS = 3'(LOSS_CNT);

    state_t           r_state;
    logic [POS_W-1:0] r_pos;
    logic [2:0]       r_hit;
    logic [2:0]       r_miss;
    logic             r_lock;
    logic             r_pulse;

    logic w_match;
    logic w_check;
    logic w_clr;

    assign w_check = in_valid && (r_pos == POS_LAST);
    // Window is wiped on a HUNT hit so the next word cannot overlap this one
    assign w_clr   = !enable || ((r_state == HUNT) && w_match);

    sync_word_det #(
        .PATTERN (PATTERN)
    ) u_det (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (w_clr),
        .in       (in),
        .in_valid (in_valid),
        .match    (w_match)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= HUNT;
            r_pos   <= '0;
            r_hit   <= '0;
            r_miss  <= '0;
            r_lock  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (!enable) begin
                r_state <= HUNT;
                r_pos   <= '0;
                r_hit   <= '0;
                r_miss  <= '0;
                r_lock  <= 1'b0;
            end else begin
                case (r_state)
                    HUNT: begin
                        if (w_match) begin
                            r_pulse <= 1'b1;
                            r_pos   <= '0;
                            r_hit   <= 3'd1;
                            if (HIT_LOCK == 3'd1) begin
                                r_state <= LOCK;
                                r_lock  <= 1'b1;
                            end else begin
                                r_state <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (in_valid) begin
                            r_pos <= w_check ? '0 : r_pos + POS_ONE;
                        end
                        if (w_check) begin
                            if (w_match) begin
                                r_pulse <= 1'b1;
                                r_hit   <= r_hit + 3'd1;
                                if (r_hit + 3'd1 == HIT_LOCK) begin
                                    r_state <= LOCK;
                                    r_lock  <= 1'b1;
                                    r_miss  <= '0;
                                end
                            end else begin
                                r_state <= HUNT;
                                r_hit   <= '0;
                            end
                        end
                    end
                    LOCK: begin
                        if (in_valid) begin
                            r_pos <= w_check ? '0 : r_pos + POS_ONE;
                        end
                        if (w_check) begin
                            if (w_match) begin
                                r_pulse <= 1'b1;
                                r_miss  <= '0;
                            end else if (r_miss + 3'd1 == MISS_LOSS) begin
                                r_state <= HUNT;
                                r_lock  <= 1'b0;
                                r_miss  <= '0;
                                r_hit   <= '0;
                            end else begin
                                r_miss <= r_miss + 3'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= HUNT;
                        r_pos   <= '0;
                        r_hit   <= '0;
                        r_miss  <= '0;
                        r_lock  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign lock       = r_lock;
    assign sync_pulse = r_pulse;
    assign state      = r_state;
    assign miss_cnt   = r_miss;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Scoreboard bench for frame_sync_ctrl with FRAME_LEN=8, LOCK_CNT=2,
// LOSS_CNT=3, PATTERN=1010.
module tb_frame_sync_ctrl;

    localparam int FLEN = 8;

    logic       clk;
    logic       rstn;
    logic       enable;
    logic       din;
    logic       vld;
    logic       lock;
    logic       sync_pulse;
    logic [1:0] state;
    logic [2:0] miss_cnt;

    frame_sync_ctrl #(
        .PATTERN   (4'b1010),
        .FRAME_LEN (FLEN),
        .LOCK_CNT  (2),
        .LOSS_CNT  (3)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .in         (din),
        .in_valid   (vld),
        .lock       (lock),
        .sync_pulse (sync_pulse),
        .state      (state),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_pass = 0;
    string phase  = "init";

    logic [6:0] exp_q[$];

    // reference model: counts valid bits since the last accepted sync word
    logic [3:0] m_win;
    int         m_st;
    int         m_since;
    int         m_hit;
    int         m_miss;
    logic       m_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
    endtask

    task automatic model_reset();
        m_win = '0; m_st = 0; m_since = 0; m_hit = 0; m_miss = 0; m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic v, input logic b);
        logic [3:0] nw;
        logic       hit;
        m_pulse = 1'b0;
        if (!en) begin
            model_reset();
            return;
        end
        if (!v) return;
        nw    = {m_win[2:0], b};
        hit   = (nw == 4'b1010);
        m_win = nw;
        if (m_st == 0) begin
            if (hit) begin
                m_st = 1; m_hit = 1; m_since = 0; m_pulse = 1'b1; m_win = '0;
            end
        end else begin
            m_since++;
            if (m_since == FLEN) begin
                m_since = 0;
                if (m_st == 1) begin
                    if (hit) begin
                        m_hit++; m_pulse = 1'b1;
                        if (m_hit == 2) m_st = 2;
                    end else begin
                        m_st = 0; m_hit = 0;
                    end
                end else if (hit) begin
                    m_miss = 0; m_pulse = 1'b1;
                end else begin
                    m_miss++;
                    if (m_miss == 3) begin
                        m_st = 0; m_miss = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [6:0] model_out();
        return {(m_st == 2), m_pulse, 2'(m_st), 3'(m_miss)};
    endfunction

    task automatic cyc(input logic en, input logic v, input logic b);
        logic [6:0] e;
        @(negedge clk);
        enable = en; vld = v; din = b;
        model_step(en, v, b);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("out", {25'd0, lock, sync_pulse, state, miss_cnt}, {25'd0, e});
    endtask

    task automatic send_frame(input logic [7:0] f, input int gap_at);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < 3; g++) cyc(1'b1, 1'b0, 1'($urandom));
            end
            cyc(1'b1, 1'b1, f[7-i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        #1;
        check("rst", {25'd0, lock, sync_pulse, state, miss_cnt}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; enable = 1'b1; vld = 1'b0; din = 1'b0;
        model_reset();

        phase = "idle";
        do_reset();
        repeat (12) cyc(1'b1, 1'b1, 1'b0);
        check("lock", {31'd0, lock}, 32'd0);

        phase = "acquire";
        send_frame(8'hA0, -1);
        check("state_v", {30'd0, state}, 32'd1);
        send_frame(8'hA0, -1);
        check("lock", {31'd0, lock}, 32'd1);
        check("state_l", {30'd0, state}, 32'd2);
        send_frame(8'hA0, -1);

        phase = "miss1";
        send_frame(8'hAA, -1);
        send_frame(8'hAA, -1);
        send_frame(8'h0A, -1);
        check("miss", {29'd0, miss_cnt}, 32'd1);
        check("lock", {31'd0, lock}, 32'd1);
        send_frame(8'hA0, -1);
        check("miss_clr", {29'd0, miss_cnt}, 32'd0);

        phase = "loss";
        send_frame(8'h00, -1);
        check("miss", {29'd0, miss_cnt}, 32'd1);
        send_frame(8'h00, -1);
        check("miss", {29'd0, miss_cnt}, 32'd2);
        send_frame(8'h00, -1);
        check("lock", {31'd0, lock}, 32'd0);
        check("state", {30'd0, state}, 32'd0);

        phase = "gaps";
        do_reset();
        send_frame(8'hA0, 5);
        check("state_v", {30'd0, state}, 32'd1);
        send_frame(8'hA0, 2);
        check("lock", {31'd0, lock}, 32'd1);
        send_frame(8'hA0, 6);

        phase = "async_rst";
        cyc(1'b1, 1'b1, 1'b1);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check("lock", {31'd0, lock}, 32'd0);
        check("state", {30'd0, state}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        send_frame(8'hA0, -1);
        check("state_v", {30'd0, state}, 32'd1);
        send_frame(8'hA0, -1);
        check("relock", {31'd0, lock}, 32'd1);

        phase = "enable";
        do_reset();
        send_frame(8'hA0, -1);
        check("state_v", {30'd0, state}, 32'd1);
        cyc(1'b0, 1'b1, 1'b1);
        check("state", {30'd0, state}, 32'd0);
        send_frame(8'hA0, -1);
        check("lock_early", {31'd0, lock}, 32'd0);
        send_frame(8'hA0, -1);
        check("relock", {31'd0, lock}, 32'd1);

        phase = "random";
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 5))
                0:       send_frame(8'($urandom), -1);
                1:       cyc(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom));
                2:       send_frame(8'hA0 | 8'($urandom_range(0, 15)), $urandom_range(0, 9));
                default: send_frame(8'hA0 | 8'($urandom_range(0, 15)), -1);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_sync_ctrl.md
FRAME_SYNC_CTRL -- requirements
Module: frame_sync_ctrl

Interface
REQ-001 SHALL have parameter PATTERN, default 4'b1010, sync word; MSB is received first.
REQ-002 SHALL have parameter FRAME_LEN, default 16, valid bits per frame period including sync word; legal range 4..255.
REQ-003 SHALL have parameter LOCK_CNT, default 2, consecutive on-position sync words needed to declare lock; legal range 1..7.
REQ-004 SHALL have parameter LOSS_CNT, default 3, consecutive on-position misses that drop lock; legal range 1..7.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port enable  input  1  1 = run; 0 = hold controller in HUNT with all counters cleared.
REQ-008 SHALL have port in  input  1  serial data bit.
REQ-009 SHALL have port in_valid  input  1  qualifies in; cycles with in_valid=0 are ignored entirely.
REQ-010 SHALL have port lock  output  1  high while in LOCK.
REQ-011 SHALL have port sync_pulse  output  1  one-cycle pulse per accepted sync word.
REQ-012 SHALL have port state  output  2  0=HUNT, 1=VERIFY, 2=LOCK.
REQ-013 SHALL have port miss_cnt  output  3  current consecutive-miss count in LOCK.

Function
REQ-014 SHALL keep a 4-bit shift window; on each valid bit, window_next = {window[2:0], in}; match = (window_next == PATTERN).
REQ-015 SHALL keep pos counter, width clog2(FRAME_LEN); advances only on valid bits; a valid bit with pos == FRAME_LEN-1 is a check bit, after which pos returns to 0.
REQ-016 HUNT: on any valid bit with match -> VERIFY, pos=0, hit count=1, sync_pulse; if LOCK_CNT==1 -> LOCK directly.
REQ-017 HUNT: after a match the window SHALL be cleared to 0 (non-overlapping detection).
REQ-018 VERIFY: matches on non-check bits SHALL be ignored; check bit with match -> hit count +1, sync_pulse; reaching LOCK_CNT -> LOCK.
REQ-019 VERIFY: check bit without match -> HUNT, hit count cleared, window kept.
REQ-020 LOCK: check bit with match -> miss_cnt=0, sync_pulse; off-position matches ignored.
REQ-021 LOCK: check bit without match -> miss_cnt +1; when the new value equals LOSS_CNT -> HUNT, miss_cnt=0.
REQ-022 All outputs SHALL be registered and reflect a valid bit on the cycle after the clock edge that sampled it (latency 1).
REQ-023 enable=0 SHALL take priority over in_valid on the same edge; enable rising SHALL resume in HUNT with window=0.
REQ-024 The pos and miss_cnt counters SHALL never wrap; saturation is unreachable within the legal parameter ranges.
REQ-025 Undefined state encoding (3) SHALL recover to HUNT on the next edge.

Reset
REQ-026 rstn low SHALL immediately force state=HUNT, lock=0, sync_pulse=0, miss_cnt=0, pos=0, window=0, hit count=0, regardless of clk.
REQ-027 Reset asserted mid-LOCK SHALL drop lock asynchronously; the first valid bit after release is treated as a fresh HUNT bit.

Structure
REQ-028 State encodings (HUNT/VERIFY/LOCK) and the pattern width constant (4) SHALL live in shared package fsm_pkg.
REQ-029 Window shift register and match compare SHALL be one sub-module, sync_word_det (inputs clk, rstn, clr, in, in_valid; output match).
REQ-030 The controller FSM, pos counter, hit counter and miss counter SHALL reside in frame_sync_ctrl.

Verification (FRAME_LEN=8, LOCK_CNT=2, LOSS_CNT=3, PATTERN=1010, in_valid=1 unless stated)
REQ-031 Reset then idle zeros -> lock=0, state=0, sync_pulse=0, miss_cnt=0 throughout.
REQ-032 Repeat frame 1010_0000 -> sync_pulse after bits 4 and 12; state=1 after bit 4; lock=1 and state=2 after bit 12.
REQ-033 Locked; frame payload 1010_1010 -> off-position match ignored; one corrupted sync word 0000 -> miss_cnt=1, lock stays 1; next good sync word -> miss_cnt=0.
REQ-034 Locked; three consecutive corrupted sync words -> miss_cnt 1,2; on the third, state=0 and lock=0 one cycle after the third check bit.
REQ-035 Same stream as REQ-032 with in_valid=0 for 3 cycles inside each frame -> identical lock point counted in valid bits; pos frozen during gaps.
REQ-036 rstn pulsed low mid-LOCK, and separately enable=0 for one cycle mid-VERIFY -> lock=0 and state=0 immediately; relock requires 2 fresh sync words.
